aes_dmem_responder: RTL and testbench

- Memory-side responder for the CPU data port: accepts scalar 32-bit and vector 128-bit load/store requests over a valid/ready handshake.
- Serves each request from a 32-bit-wide storage array and returns one response pulse per request.
- A vector access is split into four sequential 32-bit beats.
- Sits between the RV32IMV AES core's data interface and the data store, replacing a single-cycle combinational memory with a multi-cycle, handshaked one.

---
 rtl/aes_dmem_responder.sv | 88 ++++++++
 tb/tb_aes_dmem_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_dmem_responder.sv
// aes_dmem_responder: handshaked scalar/vector data memory; scalar accesses take one beat, vector accesses take four.
// Defining DMEM_ALIGN_CHECK_EN rejects misaligned requests with err instead of touching storage.
module aes_dmem_responder #(
  parameter int VLEN        = 128,
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     addr,
  input  logic [VLEN-1:0] wdata,
  input  logic [3:0]      wmem,
  input  logic            vector,
  output logic [VLEN-1:0] rdata,
  output logic            rsp_valid,
  output logic            err
);
  typedef enum logic [1:0] {IDLE, SCALAR, VBEAT, RESP} state_t;
  state_t state, state_nx;
  logic [1:0] beat;
  logic [ADDR_W-1:0] a_addr, idx;
  logic [VLEN-1:0] a_wdata;
  logic [3:0] a_wmem;
  logic a_vec, accept, misal, we, unused_addr;
  logic [31:0] cur, vec_word, nxt_word;
  logic [31:0] mem [DEPTH_WORDS];
  assign accept      = req_valid & req_ready;
  assign req_ready   = (state == IDLE) & ~clrn;
  assign rsp_valid   = state == RESP;
  assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};
`ifdef DMEM_ALIGN_CHECK_EN
  logic err_q;
  assign misal = vector ? |addr[3:0] : |addr[1:0];
  assign err   = rsp_valid & err_q;
  always_ff @(posedge clk or posedge clrn)
    if (clrn) err_q <= 1'b0;
    else if (accept) err_q <= misal;
`else
  assign misal = 1'b0;
  assign err   = 1'b0;
`endif
  // vector beats walk the four words of the 16-byte block the address falls in
  always_comb begin
    idx      = a_vec ? {a_addr[ADDR_W-1:2], beat} : a_addr;
    cur      = mem[idx];
    vec_word = a_wdata[{beat, 5'b0} +: 32];
    nxt_word = a_vec ? (|a_wmem ? vec_word : cur)
                     : {a_wmem[3] ? a_wdata[31:24] : cur[31:24],
                        a_wmem[2] ? a_wdata[23:16] : cur[23:16],
                        a_wmem[1] ? a_wdata[15:8]  : cur[15:8],
                        a_wmem[0] ? a_wdata[7:0]   : cur[7:0]};
    we       = |a_wmem & ((state == SCALAR) | (state == VBEAT));
    state_nx = state == IDLE   ? (accept ? (misal ? RESP : vector ? VBEAT : SCALAR) : IDLE)
             : state == SCALAR ? RESP
             : state == VBEAT  ? (beat == 2'd3 ? RESP : VBEAT)
             : IDLE;
  end
  always_ff @(posedge clk or posedge clrn)
    if (clrn) begin
      state   <= IDLE;
      beat    <= 2'd0;
      a_addr  <= '0;
      a_wdata <= '0;
      a_wmem  <= 4'd0;
      a_vec   <= 1'b0;
      rdata   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_addr  <= addr[ADDR_W+1:2];
        a_wdata <= wdata;
        a_wmem  <= wmem;
        a_vec   <= vector;
        beat    <= 2'd0;
        if (misal) rdata <= '0;
      end
      if (state == SCALAR) rdata <= {{(VLEN-32){1'b0}}, nxt_word};
      if (state == VBEAT) begin
        rdata[{beat, 5'b0} +: 32] <= nxt_word;
        beat <= beat + 2'd1;
      end
    end
  // storage is deliberately left out of reset
  always_ff @(posedge clk)
    if (we) mem[idx] <= nxt_word;
endmodule

// File: tb/tb_aes_dmem_responder.sv
// tb_aes_dmem_responder: table vectors, corner-case sequences and random traffic against a word-array reference model.
module tb_aes_dmem_responder;
  logic clk = 1'b0;
  logic clrn, req_valid, req_ready, vector, rsp_valid, err;
  logic [31:0] addr;
  logic [127:0] wdata, rdata;
  logic [3:0] wmem;
  int n_pass = 0, n_tot = 0, rsp_cnt = 0, n_req = 0;
  logic [31:0] mm [1024];
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  typedef struct {
    logic [31:0]  a;
    logic [127:0] wd;
    logic [3:0]   wm;
    bit           v;
    logic [127:0] er;
    bit           ee;
    int           el;
  } vec_t;
  vec_t tbl[$];

  aes_dmem_responder dut (
    .clk(clk), .clrn(clrn), .req_valid(req_valid), .req_ready(req_ready),
    .addr(addr), .wdata(wdata), .wmem(wmem), .vector(vector),
    .rdata(rdata), .rsp_valid(rsp_valid), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (rsp_valid) rsp_cnt <= rsp_cnt + 1;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic add(input logic [31:0] a, input logic [127:0] wd, input logic [3:0] wm,
                     input bit v, input logic [127:0] er, input bit ee, input int el);
    vec_t t;
    t.a = a; t.wd = wd; t.wm = wm; t.v = v; t.er = er; t.ee = ee; t.el = el;
    tbl.push_back(t);
  endtask

  // reference: plain word array, byte merge for scalars, block-of-four for vectors
  task automatic model_req(input logic [31:0] a, input logic [127:0] wd, input logic [3:0] wm,
                           input bit v, output logic [127:0] r, output bit e, output int lat);
    int unsigned w;
    r = '0; e = 1'b0;
    if (ALIGN && (v ? (a % 16) != 0 : (a % 4) != 0)) begin
      e = 1'b1; lat = 1;
      return;
    end
    if (!v) begin
      w = (a / 4) % 1024;
      for (int b = 0; b < 4; b++) if (wm[b]) mm[w][8*b +: 8] = wd[8*b +: 8];
      r[31:0] = mm[w];
      lat = 2;
    end else begin
      w = ((a / 16) * 4) % 1024;
      for (int k = 0; k < 4; k++) begin
        if (wm != 0) mm[w+k] = wd[32*k +: 32];
        r[32*k +: 32] = mm[w+k];
      end
      lat = 5;
    end
  endtask

  task automatic do_req(input logic [31:0] a, input logic [127:0] wd, input logic [3:0] wm, input bit v,
                        output logic [127:0] r, output logic e, output int lat, output bit busy_ok);
    bit acc, rdy;
    r = '0; e = 1'b0; lat = -1; busy_ok = 1'b0; acc = 1'b0;
    addr = a; wdata = wd; wmem = wm; vector = v; req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rdy = req_ready;
      @(posedge clk); #1;
      if (rdy) begin acc = 1'b1; break; end
    end
    req_valid = 1'b0;
    if (!acc) begin
      chk("accept_timeout", 1'b0, 1'b1);
      return;
    end
    n_req++;
    busy_ok = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      if (rsp_valid) begin lat = n; r = rdata; e = err; break; end
      if (req_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic run(input logic [31:0] a, input logic [127:0] wd, input logic [3:0] wm,
                     input bit v, input string nm);
    logic [127:0] r, er;
    logic e;
    bit ee, bz;
    int lat, el;
    do_req(a, wd, wm, v, r, e, lat, bz);
    model_req(a, wd, wm, v, er, ee, el);
    chk({nm, "_rdata"}, r, er);
    chk({nm, "_err"}, e, ee);
    chk({nm, "_lat"}, lat, el);
  endtask

  initial begin
    logic [127:0] r, er, nv;
    logic e;
    bit ee, bz;
    int lat, el, first_rdy, rsp_before;
    int rsp_q[$];
    logic [31:0] old2, old3;
    logic [127:0] vv, w2, w3;
    vv = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    w2 = 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978;
    w3 = 128'hA1A2A3A4_B1B2B3B4_C1C2C3C4_D1D2D3D4;
    add(32'h10, 128'h11223344, 4'hF, 1'b0, 128'h11223344, 1'b0, 2);
    add(32'h10, 128'hAABBCCDD, 4'h5, 1'b0, 128'h11BB33DD, 1'b0, 2);
    add(32'h10, 128'h0, 4'h0, 1'b0, 128'h11BB33DD, 1'b0, 2);
    add(32'h13, 128'h5555AAAA, 4'hF, 1'b0, ALIGN ? 128'h0 : 128'h5555AAAA, ALIGN, ALIGN ? 1 : 2);
    add(32'h10, 128'h0, 4'h0, 1'b0, ALIGN ? 128'h11BB33DD : 128'h5555AAAA, 1'b0, 2);
    add(32'h40, vv, 4'hF, 1'b1, vv, 1'b0, 5);
    add(32'h44, 128'h0, 4'h0, 1'b0, 128'h8899AABB, 1'b0, 2);
    add(32'h4C, 128'h0, 4'h0, 1'b1, ALIGN ? 128'h0 : vv, ALIGN, ALIGN ? 1 : 5);
    add(32'h1020, 128'hCAFEF00D, 4'hF, 1'b0, 128'hCAFEF00D, 1'b0, 2);
    add(32'h20, 128'h0, 4'h0, 1'b0, 128'hCAFEF00D, 1'b0, 2);
    add(32'h60, w3, 4'h1, 1'b1, w3, 1'b0, 5);
    add(32'h6C, 128'h0, 4'h0, 1'b0, 128'hA1A2A3A4, 1'b0, 2);
    add(32'hFFFFFFF0, w2, 4'hF, 1'b1, w2, 1'b0, 5);
    add(32'hFFC, 128'h0, 4'h0, 1'b0, 128'hFEDCBA98, 1'b0, 2);

    clrn = 1'b1; req_valid = 1'b0; addr = '0; wdata = '0; wmem = '0; vector = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_rsp", rsp_valid, 1'b0);
    chk("rst_rdata", rdata, 128'h0);
    chk("rst_err", err, 1'b0);
    clrn = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", req_ready, 1'b1);

    for (int b = 0; b < 256; b++)
      run(b * 16, {$urandom, $urandom, $urandom, $urandom}, 4'hF, 1'b1, $sformatf("init%0d", b));

    foreach (tbl[i]) begin
      do_req(tbl[i].a, tbl[i].wd, tbl[i].wm, tbl[i].v, r, e, lat, bz);
      model_req(tbl[i].a, tbl[i].wd, tbl[i].wm, tbl[i].v, er, ee, el);
      chk($sformatf("tbl%0d_rdata", i), r, tbl[i].er);
      chk($sformatf("tbl%0d_err", i), e, tbl[i].ee);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].el);
      chk($sformatf("tbl%0d_busy", i), bz, 1'b1);
    end

    @(posedge clk); #1;
    clrn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_rst_ready", req_ready, 1'b0);
    chk("idle_rst_rsp", rsp_valid, 1'b0);
    chk("idle_rst_rdata", rdata, 128'h0);
    clrn = 1'b0;
    @(posedge clk); #1;
    chk("idle_rst_ready_after", req_ready, 1'b1);

    // two back-to-back requests with req_valid held high
    addr = 32'h200; wdata = 128'hDEADBEEF; wmem = 4'hF; vector = 1'b0; req_valid = 1'b1;
    chk("bp_ready_a", req_ready, 1'b1);
    @(posedge clk); #1;
    model_req(32'h200, 128'hDEADBEEF, 4'hF, 1'b0, er, ee, el);
    addr = 32'h204; wdata = 128'h0BADCAFE;
    first_rdy = 0;
    for (int i = 1; i <= 10; i++) begin
      if (rsp_valid) rsp_q.push_back(i);
      if (req_ready && first_rdy == 0) first_rdy = i;
      if (first_rdy != 0 && i == first_rdy + 1) req_valid = 1'b0;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    model_req(32'h204, 128'h0BADCAFE, 4'hF, 1'b0, er, ee, el);
    n_req += 2;
    chk("bp_first_ready", first_rdy, 3);
    chk("bp_rsp_count", rsp_q.size(), 2);
    chk("bp_rsp_a", rsp_q.size() > 0 ? rsp_q[0] : -1, 2);
    chk("bp_rsp_b", rsp_q.size() > 1 ? rsp_q[1] : -1, 5);
    run(32'h200, 128'h0, 4'h0, 1'b0, "bp_load_a");
    run(32'h204, 128'h0, 4'h0, 1'b0, "bp_load_b");

    // reset lands after beat 1 of a vector store
    nv = 128'h99999999_88888888_77777777_66666666;
    old2 = mm[34];
    old3 = mm[35];
    @(posedge clk); #1;
    rsp_before = rsp_cnt;
    addr = 32'h80; wdata = nv; wmem = 4'hF; vector = 1'b1; req_valid = 1'b1;
    chk("rv_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clrn = 1'b1;
    #1;
    chk("rv_rsp", rsp_valid, 1'b0);
    chk("rv_rdata", rdata, 128'h0);
    chk("rv_ready_in_rst", req_ready, 1'b0);
    @(posedge clk); #1;
    clrn = 1'b0;
    @(posedge clk); #1;
    chk("rv_idle", req_ready, 1'b1);
    chk("rv_no_rsp", rsp_cnt, rsp_before);
    mm[32] = nv[31:0];
    mm[33] = nv[63:32];
    do_req(32'h80, 128'h0, 4'h0, 1'b0, r, e, lat, bz);
    chk("rv_w0", r, 128'h66666666);
    do_req(32'h84, 128'h0, 4'h0, 1'b0, r, e, lat, bz);
    chk("rv_w1", r, 128'h77777777);
    do_req(32'h88, 128'h0, 4'h0, 1'b0, r, e, lat, bz);
    chk("rv_w2", r, {96'h0, old2});
    do_req(32'h8C, 128'h0, 4'h0, 1'b0, r, e, lat, bz);
    chk("rv_w3", r, {96'h0, old3});

    for (int i = 0; i < 150; i++)
      run($urandom, {$urandom, $urandom, $urandom, $urandom},
          $urandom_range(0, 1) ? 4'h0 : 4'($urandom), 1'($urandom), $sformatf("rnd%0d", i));

    repeat (3) @(posedge clk);
    #1;
    chk("rsp_count", rsp_cnt, n_req);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
